bwt_stream_top: RTL and testbench

BWT_STREAM_TOP -- requirements
Module: bwt_stream_top

---
 rtl/bwt_stream_top.sv | 177 +++++++++++++++++
 tb/tb_bwt_stream_top.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bwt_stream_top.sv
// Streaming Burrows-Wheeler transform: load a block, rank every rotation,
// stream out the last column. Optional macro BWT_PRIMARY_IDX_EN keeps the
// primary index (sorted rank of rotation 0) on out_index; otherwise it is 0.
// Ports: clk, rst (sync, active-low), in_valid/in_ready/in_char (input
// stream), out_valid/out_ready/out_char/out_last/out_index (output stream),
// busy (high in SORT and SEND).
module bwt_stream_top #(
   parameter  int STRING_LEN = 8,
   parameter  int CHAR_W     = 8,
   localparam int IDX_W      = (STRING_LEN > 2) ? $clog2(STRING_LEN) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CHAR_W-1:0] in_char,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CHAR_W-1:0] out_char,
   output logic              out_last,
   output logic [IDX_W-1:0]  out_index,
   output logic              busy
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(STRING_LEN - 1);
   localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0] ZERO = '0;

   typedef enum logic [1:0] {LOAD, SORT, SEND} state_t;

   state_t state;

   logic [CHAR_W-1:0] s   [STRING_LEN];
   logic [CHAR_W-1:0] bwt [STRING_LEN];

   logic [IDX_W-1:0] cnt, ptr;
   logic [IDX_W-1:0] i, j, k, pi, pj, rank;
   logic             wr;

   logic [CHAR_W-1:0] ci, cj;
   logic              pair_done, contrib, last_j;
   logic [IDX_W:0]    j1, j_nx;
   logic [IDX_W-1:0]  pi_inc, pj_inc, prev_i, rank_nx;

   assign ci = s[pi];
   assign cj = s[pj];

   // pi/pj walk (i+k) mod N and (j+k) mod N, wrapping at N
   always_comb begin
      pair_done = (ci != cj) || (k == LAST);
      contrib   = (ci > cj) || ((ci == cj) && (j < i));
      j1        = {1'b0, j} + {{IDX_W{1'b0}}, 1'b1};
      j_nx      = (j1 == {1'b0, i}) ? j1 + {{IDX_W{1'b0}}, 1'b1} : j1;
      last_j    = (j_nx > {1'b0, LAST});
      pi_inc    = (pi == LAST) ? ZERO : pi + ONE;
      pj_inc    = (pj == LAST) ? ZERO : pj + ONE;
      prev_i    = (i == ZERO) ? LAST : i - ONE;
      rank_nx   = rank + IDX_W'(contrib);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= LOAD;
         cnt       <= '0;
         ptr       <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         wr        <= 1'b0;
         i         <= '0;
         j         <= '0;
         k         <= '0;
         pi        <= '0;
         pj        <= '0;
         rank      <= '0;
      end else begin
         unique case (state)
            LOAD: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  if (cnt == LAST) begin
                     cnt      <= '0;
                     in_ready <= 1'b0;
                     busy     <= 1'b1;
                     state    <= SORT;
                     i        <= '0;
                     j        <= ONE;
                     pi       <= '0;
                     pj       <= ONE;
                     k        <= '0;
                     rank     <= '0;
                     wr       <= 1'b0;
                  end else begin
                     cnt <= cnt + ONE;
                  end
               end
            end
            SORT: begin
               if (wr) begin
                  // one write cycle per rotation closes rank_i
                  wr   <= 1'b0;
                  rank <= '0;
                  k    <= '0;
                  if (i == LAST) begin
                     state     <= SEND;
                     out_valid <= 1'b1;
                     out_last  <= 1'b0;
                     ptr       <= '0;
                  end else begin
                     i  <= i + ONE;
                     pi <= i + ONE;
                     j  <= '0;
                     pj <= '0;
                  end
               end else if (pair_done) begin
                  rank <= rank_nx;
                  k    <= '0;
                  if (last_j) begin
                     wr <= 1'b1;
                  end else begin
                     j  <= j_nx[IDX_W-1:0];
                     pj <= j_nx[IDX_W-1:0];
                     pi <= i;
                  end
               end else begin
                  k  <= k + ONE;
                  pi <= pi_inc;
                  pj <= pj_inc;
               end
            end
            SEND: begin
               if (out_ready) begin
                  if (ptr == LAST) begin
                     state     <= LOAD;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     busy      <= 1'b0;
                     in_ready  <= 1'b1;
                     ptr       <= '0;
                  end else begin
                     ptr      <= ptr + ONE;
                     out_last <= ((ptr + ONE) == LAST);
                  end
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

   // storage survives reset on purpose
   always_ff @(posedge clk) begin
      if (rst && state == LOAD && in_valid && in_ready)
         s[cnt] <= in_char;
      if (rst && state == SORT && wr)
         bwt[rank] <= s[prev_i];
   end

   assign out_char = out_valid ? bwt[ptr] : '0;

`ifdef BWT_PRIMARY_IDX_EN
   logic [IDX_W-1:0] idx_q;

   always_ff @(posedge clk) begin
      if (!rst)
         idx_q <= '0;
      else if (state == SORT && wr && i == ZERO)
         idx_q <= rank;
   end

   assign out_index = idx_q;
`else
   assign out_index = '0;
`endif

endmodule

// File: tb/tb_bwt_stream_top.sv
// Self-checking bench for bwt_stream_top: N=6 and N=4 instances fed
// directed strings, compared every output beat against a rotation-sort model.
module tb_bwt_stream_top;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst6, iv6, ir6, ov6, or6, ol6, busy6;
   logic [7:0] ic6, oc6;
   logic [2:0] ox6;
   logic       rst4, iv4, ir4, ov4, or4, ol4, busy4;
   logic [7:0] ic4, oc4;
   logic [1:0] ox4;

   bwt_stream_top #(.STRING_LEN(6), .CHAR_W(8)) dut6 (
      .clk(clk), .rst(rst6), .in_valid(iv6), .in_ready(ir6),
      .in_char(ic6), .out_valid(ov6), .out_ready(or6),
      .out_char(oc6), .out_last(ol6), .out_index(ox6), .busy(busy6));

   bwt_stream_top #(.STRING_LEN(4), .CHAR_W(8)) dut4 (
      .clk(clk), .rst(rst4), .in_valid(iv4), .in_ready(ir4),
      .in_char(ic4), .out_valid(ov4), .out_ready(or4),
      .out_char(oc4), .out_last(ol4), .out_index(ox4), .busy(busy4));

   typedef struct {
      logic [7:0] c;
      bit         last;
      int         idx;
   } exp_t;

   exp_t       e6[$], e4[$];
   logic [7:0] q6[$], q4[$];
   int         n_checks = 0;
   int         n_fail = 0;
   int         mode6 = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Rank every rotation by full lexicographic compare, ties by index
   function automatic void model(input string str,
                                 output logic [7:0] o [256],
                                 output int idx);
      int n;
      n = str.len();
      idx = 0;
      for (int x = 0; x < 256; x++) o[x] = 8'h00;
      for (int a = 0; a < n; a++) begin
         int rank;
         rank = 0;
         for (int b = 0; b < n; b++) begin
            if (b != a) begin
               int c;
               c = 0;
               for (int t = 0; t < n && c == 0; t++) begin
                  logic [7:0] ca, cb;
                  ca = str[(a + t) % n];
                  cb = str[(b + t) % n];
                  if (ca < cb) c = -1;
                  else if (ca > cb) c = 1;
               end
               if (c > 0 || (c == 0 && b < a)) rank++;
            end
         end
         o[rank] = str[(a + n - 1) % n];
         if (a == 0) idx = rank;
      end
   endfunction

   task automatic enqueue(input bit sel, input string str);
      logic [7:0] o [256];
      int idx, n;
      exp_t e;
      model(str, o, idx);
`ifndef BWT_PRIMARY_IDX_EN
      idx = 0;
`endif
      n = str.len();
      for (int x = 0; x < n; x++) begin
         e.c = o[x];
         e.last = (x == n - 1);
         e.idx = idx;
         if (sel) begin
            q4.push_back(str[x]);
            e4.push_back(e);
         end else begin
            q6.push_back(str[x]);
            e6.push_back(e);
         end
      end
   endtask

   task automatic pin_model(input string str, input string ref_s, input int ref_idx);
      logic [7:0] o [256];
      int idx;
      model(str, o, idx);
      for (int x = 0; x < str.len(); x++)
         check({"model_", str}, int'(o[x]), int'(ref_s[x]));
      check({"model_idx_", str}, idx, ref_idx);
   endtask

   task automatic drain(input int bound);
      int c;
      c = 0;
      while ((q6.size() + e6.size() + q4.size() + e4.size()) > 0 && c < bound) begin
         @(negedge clk);
         c++;
      end
      check("drain_in_time", int'(c < bound), 1);
      repeat (2) @(negedge clk);
   endtask

   // input drivers: decide at negedge, pop after the edge that transferred
   initial begin
      bit fire;
      iv6 = 1'b0;
      ic6 = 8'h00;
      forever begin
         @(negedge clk);
         fire = iv6 && ir6;
         @(posedge clk);
         #1;
         if (fire) void'(q6.pop_front());
         if (q6.size() > 0) begin
            iv6 = 1'b1;
            ic6 = q6[0];
         end else begin
            iv6 = 1'b0;
         end
      end
   end

   initial begin
      bit fire;
      iv4 = 1'b0;
      ic4 = 8'h00;
      forever begin
         @(negedge clk);
         fire = iv4 && ir4;
         @(posedge clk);
         #1;
         if (fire) void'(q4.pop_front());
         if (q4.size() > 0) begin
            iv4 = 1'b1;
            ic4 = q4[0];
         end else begin
            iv4 = 1'b0;
         end
      end
   end

   initial begin
      bit pat [4];
      int pidx;
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      pidx = 0;
      or6 = 1'b1;
      or4 = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (mode6 == 1) begin
            or6 = pat[pidx];
            pidx = (pidx + 1) % 4;
         end else begin
            or6 = 1'b1;
         end
      end
   end

   // compare process, N=6
   initial begin
      bit rp, held, in_send;
      int sc;
      logic [7:0] hc;
      logic hl;
      logic [2:0] hx;
      exp_t e;
      rp = 0; held = 0; in_send = 0; sc = 0;
      forever begin
         @(negedge clk);
         if (rst6 && rp) begin
            check("ready6_vs_busy", int'(ir6), int'(!busy6));
            if (held) begin
               check("hold6_valid", int'(ov6), 1);
               check("hold6_char", int'(oc6), int'(hc));
               check("hold6_last", int'(ol6), int'(hl));
               check("hold6_index", int'(ox6), int'(hx));
               held = 0;
            end
            if (busy6 && !ov6) sc++;
            if (ov6) begin
               if (!in_send) begin
                  check("sort6_cycles_le_186", int'(sc <= 186), 1);
                  in_send = 1;
                  sc = 0;
               end
               if (or6) begin
                  check("pending6", int'(e6.size() > 0), 1);
                  if (e6.size() > 0) begin
                     e = e6.pop_front();
                     check("char6", int'(oc6), int'(e.c));
                     check("last6", int'(ol6), int'(e.last));
                     check("index6", int'(ox6), e.idx);
                  end
               end else begin
                  held = 1;
                  hc = oc6;
                  hl = ol6;
                  hx = ox6;
               end
            end else begin
               in_send = 0;
            end
         end else begin
            sc = 0;
            held = 0;
            in_send = 0;
         end
         rp = rst6;
      end
   end

   // compare process, N=4
   initial begin
      bit rp, in_send;
      int sc;
      exp_t e;
      rp = 0; in_send = 0; sc = 0;
      forever begin
         @(negedge clk);
         if (rst4 && rp) begin
            check("ready4_vs_busy", int'(ir4), int'(!busy4));
            if (busy4 && !ov4) sc++;
            if (ov4) begin
               if (!in_send) begin
                  check("sort4_cycles_le_52", int'(sc <= 52), 1);
                  in_send = 1;
                  sc = 0;
               end
               if (or4) begin
                  check("pending4", int'(e4.size() > 0), 1);
                  if (e4.size() > 0) begin
                     e = e4.pop_front();
                     check("char4", int'(oc4), int'(e.c));
                     check("last4", int'(ol4), int'(e.last));
                     check("index4", int'(ox4), e.idx);
                  end
               end
            end else begin
               in_send = 0;
            end
         end else begin
            sc = 0;
            in_send = 0;
         end
         rp = rst4;
      end
   end

   initial begin
      int c;
      rst6 = 1'b0;
      rst4 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready6", int'(ir6), 0);
      check("rst_out_valid6", int'(ov6), 0);
      check("rst_out_char6", int'(oc6), 0);
      check("rst_out_last6", int'(ol6), 0);
      check("rst_out_index6", int'(ox6), 0);
      check("rst_busy6", int'(busy6), 0);
      check("rst_in_ready4", int'(ir4), 0);
      check("rst_busy4", int'(busy4), 0);
      rst6 = 1'b1;
      rst4 = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_in_ready6", int'(ir6), 1);
      check("post_rst_in_ready4", int'(ir4), 1);

      pin_model("banana", "nnbaaa", 3);
      pin_model("abab", "bbaa", 0);
      pin_model("aaaa", "aaaa", 0);

      enqueue(0, "banana");
      enqueue(1, "abab");
      enqueue(1, "aaaa");
      drain(2000);

      mode6 = 1;
      enqueue(0, "banana");
      drain(2000);
      mode6 = 0;

      enqueue(0, "banana");
      enqueue(0, "cabbed");
      drain(2000);

      // two blocks complete, a third is discarded by reset mid-SORT
      enqueue(0, "fedcba");
      enqueue(0, "abcabc");
      q6.push_back("d"); q6.push_back("c"); q6.push_back("b");
      q6.push_back("a"); q6.push_back("e"); q6.push_back("d");
      c = 0;
      while (!(q6.size() == 0 && e6.size() == 0 && busy6 && !ov6) && c < 2000) begin
         @(negedge clk);
         c++;
      end
      check("third_block_in_sort", int'(c < 2000), 1);
      repeat (5) @(posedge clk);
      #1;
      rst6 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst6 = 1'b1;
      check("midsort_rst_busy", int'(busy6), 0);
      check("midsort_rst_valid", int'(ov6), 0);
      repeat (20) @(negedge clk);
      enqueue(0, "banana");
      drain(2000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
